// File: rtl/arb_mux_if.sv
// Handshake bundle between the requesters, the arb_mux selector and the consumer.
// The master modport is the side that drives requests and consumes beats.
// The slave modport is the arb_mux side.
interface arb_mux_if #(
  parameter int WIDTH = 24,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [1:0]         mode;
  logic [SELW-1:0]    sel;
  logic [NCH-1:0]     in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]     in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/arb_mux.sv
// Registered N:1 channel selector with per-channel valid/ready handshakes.
// Selection is static, fixed-priority or round-robin; the output is a
// one-entry register that can drain and refill in the same cycle.
module arb_mux #(
  parameter int WIDTH = 24,
  parameter int NCH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_mux_if.slave    bus
);
  localparam int          SELW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCH_U = NCH;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_PRIO   = 2'd1,
    MODE_RR     = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e            mode_q;
  logic             free;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;
  logic [SELW-1:0]  rr_ptr;

  assign mode_q = mode_e'(bus.mode);
  assign free   = !bus.out_valid || bus.out_ready;
  assign xfer   = rst_n && free && gnt_vld;

  // Grant selection; rr_ptr is always < NCH, so the modulo wrap never
  // visits a nonexistent channel even when NCH is not a power of two.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    unique case (mode_q)
      MODE_STATIC: begin
        for (int unsigned i = 0; i < NCH_U; i++) begin
          if (SELW'(i) == bus.sel && bus.in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt     = SELW'(i);
          end
        end
      end
      MODE_RR: begin
        for (int unsigned k = 1; k <= NCH_U; k++) begin
          idx = (32'(rr_ptr) + k) % NCH_U;
          if (!gnt_vld && bus.in_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt     = SELW'(idx);
          end
        end
      end
      default: begin
        for (int unsigned i = 0; i < NCH_U; i++) begin
          if (!gnt_vld && bus.in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt     = SELW'(i);
          end
        end
      end
    endcase
  end

  // Data of the granted channel and the one-hot accept vector.
  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      if (SELW'(i) == gnt) begin
        gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = xfer;
      end
    end
  end

  // Output register and round-robin pointer; the pointer follows every
  // accepted transfer regardless of mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= SELW'(NCH - 1);
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= gnt_data;
      bus.out_ch    <= gnt;
      rr_ptr        <= gnt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: reset, round-robin, static, backpressure,
// mode switching and asynchronous reset during a stall.
module tb_arb_mux;
  localparam int WIDTH = 24;
  localparam int NCH   = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arb_mux_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    bus.in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every channel requesting: nothing accepted.
    rst_n         = 1'b0;
    bus.mode      = 2'd1;
    bus.sel       = '0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    set_data(0, 24'h111111);
    set_data(1, 24'h222222);
    set_data(2, 24'h333333);
    set_data(3, 24'h444444);
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("prio_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("prio_out_valid", 32'(bus.out_valid), 32'h1);
    chk("prio_out_ch", 32'(bus.out_ch), 32'h0);
    chk("prio_out_data", 32'(bus.out_data), 32'h111111);

    // Fresh reset so round-robin starts from rr_ptr = NCH-1.
    bus.in_valid = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    bus.mode     = 2'd2;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < NCH; i++) set_data(i, 24'h0000A0 + 24'(i));
    #1;
    chk("rr_first_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", 32'(bus.out_valid), 32'h1);
      chk("rr_ch", 32'(bus.out_ch), 32'(k % 4));
      chk("rr_data", 32'(bus.out_data), 32'h0000A0 + 32'(k % 4));
    end

    // Static select of channel 2.
    bus.mode     = 2'd0;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    set_data(2, 24'hABCDEF);
    #1;
    chk("stat_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("stat_out_data", 32'(bus.out_data), 32'hABCDEF);
    chk("stat_out_ch", 32'(bus.out_ch), 32'h2);
    bus.in_valid = 4'b1011;
    #1;
    chk("stat_no_grant", 32'(bus.in_ready), 32'h0);
    tick();
    chk("stat_drain_valid", 32'(bus.out_valid), 32'h0);
    chk("stat_hold_data", 32'(bus.out_data), 32'hABCDEF);

    // Backpressure on a channel-1 stream.
    bus.mode     = 2'd1;
    bus.in_valid = 4'b0010;
    set_data(1, 24'h100001);
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bp_first", 32'(bus.out_data), 32'h100001);
    set_data(1, 24'h100002);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("bp_stall_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_stall_data", 32'(bus.out_data), 32'h100001);
      chk("bp_stall_ch", 32'(bus.out_ch), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_refill_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bp_refill_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_refill_data", 32'(bus.out_data), 32'h100002);
    set_data(1, 24'h100003);
    tick();
    chk("bp_next_data", 32'(bus.out_data), 32'h100003);
    bus.in_valid = 4'b0000;
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'h0);

    // Mode switch: pointer set to 0 by a priority beat, then RR 1,2,
    // a priority beat on 0, and RR resumes at 1.
    bus.in_valid = 4'b0001;
    tick();
    chk("ms_seed", 32'(bus.out_ch), 32'h0);
    bus.mode     = 2'd2;
    bus.in_valid = 4'b1111;
    tick();
    chk("ms_rr1", 32'(bus.out_ch), 32'h1);
    tick();
    chk("ms_rr2", 32'(bus.out_ch), 32'h2);
    bus.mode = 2'd1;
    tick();
    chk("ms_prio0", 32'(bus.out_ch), 32'h0);
    bus.mode = 2'd2;
    tick();
    chk("ms_rr_resume", 32'(bus.out_ch), 32'h1);

    // Asynchronous reset while a beat is stalled.
    bus.out_ready = 1'b0;
    #2;
    chk("mid_stall_valid", 32'(bus.out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_data", 32'(bus.out_data), 32'h0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("post_rst_ch", 32'(bus.out_ch), 32'h0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised, registered N:1 channel selector with per-channel valid/ready handshakes and a one-entry output register.
- Generalises the processor's combinational 4:1 datapath mux in three ways: width and channel count are parameters, the output is pipelined, and selection is static, fixed-priority or round-robin.
- Sits between multiple requesters (fetch, load/store, debug) and a shared consumer such as a memory port or writeback bus.

Parameters:
- WIDTH, 24, data width per channel in bits.
- NCH, 4, number of input channels (2..16); derived SELW = max(1, clog2(NCH)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- mode  input  2  selection mode: 0 static, 1 fixed priority, 2 round-robin, 3 reserved (behaves as 1).
- sel  input  SELW  channel index used in static mode.
- in_valid  input  NCH  per-channel request valid.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; combinational, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync-released use): out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1. in_ready=0 while rst_n=0.
- Slot free: free = !out_valid || out_ready.
- Grant is computed combinationally each cycle from mode, sel, in_valid and rr_ptr:
  - Static mode: grant = sel if sel<NCH and in_valid[sel]; otherwise no grant. sel>=NCH never grants.
  - Fixed priority: lowest-index valid channel wins.
  - Round-robin: first valid channel searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NCH.
- in_ready[g] = free && grant valid. All other in_ready bits are 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- If out_ready && out_valid with no new transfer, then out_valid <= 0; out_data and out_ch hold their last values.
- Simultaneous drain and fill in one cycle: new beat loaded, out_valid stays 1. Throughput is 1 beat/cycle.
- Latency: input accept to out_valid is 1 cycle.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable and all in_ready=0.
- rr_ptr updates to g only on an accepted transfer, in any mode. Round-robin fairness state therefore persists across mode changes.
- mode and sel changes take effect on the same cycle's grant. No transfer is lost or duplicated.
- Sources may drop in_valid without a transfer. The block does not require sources to hold a request.
- Async reset mid-stall discards the held beat. Nothing is replayed after reset.
- NCH not a power of two: the round-robin wrap skips nonexistent indices.

Test Plan:
- Reset then idle: rst_n=0 with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0. Release reset, mode=1, out_ready=1 -> channel 0 granted; next cycle out_ch=0, out_data=in_data[0].
- Round-robin fairness: mode=2, in_valid=1111 constant, out_ready=1, in_data[i]=24'h0000A0+i for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with one beat per cycle and no gaps.
- Static select: mode=0, sel=2, in_valid=0100, in_data[2]=24'hABCDEF -> in_ready=0100; next cycle out_data=24'hABCDEF, out_ch=2. With in_valid=1011 -> no grant and out_valid falls to 0.
- Backpressure: mode=1, stream on ch1, then out_ready=0 for 3 cycles -> out_data and out_ch frozen, in_ready=0000. Raising out_ready -> drain and fill in the same cycle with no lost beat (compare against a scoreboard).
- Mode switch: round-robin grants ch1 and ch2, switch to mode=1 for one beat (ch0 wins), return to mode=2 -> next grant is ch1 (rr_ptr=0).
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 asynchronously -> out_valid=0 immediately without a clock edge, and rr_ptr is back to NCH-1.
